// File: rtl/cpu_exec_mem.sv
// cpu_exec_mem: execute/memory slice of the 32-bit CPU.
// Holds the ALU, the NZCV status register, LOAD/STORE sequencing and a
// single-port word-addressed RAM shared by an external preload port, the
// execute stage and instruction fetch (in that priority order).
module cpu_exec_mem #(
  parameter int DEPTH = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_en,
  input  logic        ext_read_write,
  input  logic [15:0] ext_address,
  input  logic [31:0] ext_data_in,
  input  logic        fetch,
  input  logic [15:0] PC_out,
  input  logic        exec,
  input  logic [31:0] instruction,
  input  logic [31:0] source_1,
  input  logic [31:0] source_2,
  output logic [31:0] data_out,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic [31:0] LDR,
  output logic        ldr_valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_ORR  = 4'h3,
    OP_EOR  = 4'h4, OP_MOV  = 4'h5, OP_MOVI = 4'h6, OP_CMP  = 4'h7,
    OP_ADDI = 4'h8, OP_SUBI = 4'h9, OP_LSL  = 4'hA, OP_LSR  = 4'hB,
    OP_MVN  = 4'hC, OP_LOAD = 4'hD, OP_STOR = 4'hE, OP_NOP  = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    C_AL = 4'h0, C_EQ = 4'h1, C_NE = 4'h2, C_CS = 4'h3,
    C_CC = 4'h4, C_MI = 4'h5, C_PL = 4'h6, C_VS = 4'h7,
    C_VC = 4'h8, C_HI = 4'h9, C_LS = 4'hA, C_GE = 4'hB,
    C_LT = 4'hC, C_GT = 4'hD, C_LE = 4'hE, C_NV = 4'hF
  } cond_e;

  logic [31:0] mem [DEPTH];

  logic [31:0] dataOut_q;
  logic [31:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic [31:0] ldr_q, ldr_d;
  logic        ldrValid_q, ldrValid_d;
  logic        loadPend_q, loadPend_d;

  opcode_e     opCode;
  cond_e       condCode;
  logic        sBit;
  logic [31:0] imm;
  logic        condPass;
  logic        execOk;

  logic [31:0] opB;
  logic [32:0] sum;
  logic [32:0] diff;
  logic [31:0] aluValue;
  logic        aluC, aluV;
  logic        isData, isCmp;

  logic          ramWe, ramRe;
  logic [AW-1:0] ramAddr;
  logic [31:0]   ramWdata;

  logic unusedBits;

  assign opCode     = opcode_e'(instruction[27:24]);
  assign condCode   = cond_e'(instruction[31:28]);
  assign sBit       = instruction[23];
  assign imm        = {16'h0000, instruction[18:3]};
  assign execOk     = exec & condPass;
  assign unusedBits = ^{instruction[22:19], instruction[2:0]};

  // Evaluate the instruction's condition against the current NZCV flags.
  always_comb begin
    condPass = 1'b0;
    case (condCode)
      C_AL: condPass = 1'b1;
      C_EQ: condPass = flags_q[2];
      C_NE: condPass = ~flags_q[2];
      C_CS: condPass = flags_q[1];
      C_CC: condPass = ~flags_q[1];
      C_MI: condPass = flags_q[3];
      C_PL: condPass = ~flags_q[3];
      C_VS: condPass = flags_q[0];
      C_VC: condPass = ~flags_q[0];
      C_HI: condPass = flags_q[1] & ~flags_q[2];
      C_LS: condPass = ~flags_q[1] | flags_q[2];
      C_GE: condPass = (flags_q[3] == flags_q[0]);
      C_LT: condPass = (flags_q[3] != flags_q[0]);
      C_GT: condPass = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      C_LE: condPass = flags_q[2] | (flags_q[3] != flags_q[0]);
      default: condPass = 1'b0;
    endcase
  end

  // ALU: compute the op's value plus carry/overflow; logical ops keep C and V.
  always_comb begin
    opB      = ((opCode == OP_ADDI) || (opCode == OP_SUBI)) ? imm : source_2;
    sum      = {1'b0, source_1} + {1'b0, opB};
    diff     = {1'b0, source_1} - {1'b0, opB};
    aluValue = '0;
    aluC     = flags_q[1];
    aluV     = flags_q[0];
    isData   = 1'b0;
    isCmp    = 1'b0;
    case (opCode)
      OP_ADD, OP_ADDI: begin
        aluValue = sum[31:0];
        aluC     = sum[32];
        aluV     = (source_1[31] == opB[31]) && (sum[31] != source_1[31]);
        isData   = 1'b1;
      end
      OP_SUB, OP_SUBI, OP_CMP: begin
        aluValue = diff[31:0];
        aluC     = ~diff[32];
        aluV     = (source_1[31] != opB[31]) && (diff[31] != source_1[31]);
        isData   = (opCode != OP_CMP);
        isCmp    = (opCode == OP_CMP);
      end
      OP_AND:  begin aluValue = source_1 & source_2;       isData = 1'b1; end
      OP_ORR:  begin aluValue = source_1 | source_2;       isData = 1'b1; end
      OP_EOR:  begin aluValue = source_1 ^ source_2;       isData = 1'b1; end
      OP_MOV:  begin aluValue = source_2;                  isData = 1'b1; end
      OP_MOVI: begin aluValue = imm;                       isData = 1'b1; end
      OP_LSL:  begin aluValue = source_1 << source_2[4:0]; isData = 1'b1; end
      OP_LSR:  begin aluValue = source_1 >> source_2[4:0]; isData = 1'b1; end
      OP_MVN:  begin aluValue = ~source_2;                 isData = 1'b1; end
      default: ;
    endcase
  end

  // Arbitrate the single RAM port: external, then exec LOAD/STORE, then fetch.
  always_comb begin
    ramWe      = 1'b0;
    ramRe      = 1'b0;
    ramAddr    = PC_out[AW-1:0];
    ramWdata   = ext_data_in;
    loadPend_d = 1'b0;
    if (ext_en) begin
      ramAddr = ext_address[AW-1:0];
      ramWe   = ~ext_read_write;
      ramRe   = ext_read_write;
    end else if (execOk && (opCode == OP_LOAD)) begin
      ramAddr    = source_1[AW-1:0];
      ramRe      = 1'b1;
      loadPend_d = 1'b1;
    end else if (execOk && (opCode == OP_STOR)) begin
      ramAddr  = source_1[AW-1:0];
      ramWe    = 1'b1;
      ramWdata = source_2;
    end else if (fetch) begin
      ramRe = 1'b1;
    end
  end

  // Next-state for write-back and flags; a completing LOAD owns LDR that cycle.
  always_comb begin
    result_d   = result_q;
    flags_d    = flags_q;
    ldr_d      = ldr_q;
    ldrValid_d = loadPend_q | (execOk & isData);
    if (execOk && isData) begin
      result_d = aluValue;
      ldr_d    = aluValue;
    end
    if (loadPend_q) begin
      ldr_d = dataOut_q;
    end
    if (execOk && (isCmp || (isData && sBit))) begin
      flags_d = {aluValue[31], (aluValue == 32'h0), aluC, aluV};
    end
  end

  // RAM array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      mem[ramAddr] <= ramWdata;
    end
  end

  // Architectural registers; reset also cancels any LOAD still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOut_q  <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      ldr_q      <= '0;
      ldrValid_q <= 1'b0;
      loadPend_q <= 1'b0;
    end else begin
      if (ramRe) begin
        dataOut_q <= mem[ramAddr];
      end
      result_q   <= result_d;
      flags_q    <= flags_d;
      ldr_q      <= ldr_d;
      ldrValid_q <= ldrValid_d;
      loadPend_q <= loadPend_d;
    end
  end

  assign data_out  = dataOut_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign LDR       = ldr_q;
  assign ldr_valid = ldrValid_q;

endmodule

// File: tb/tb_cpu_exec_mem.sv
// tb_cpu_exec_mem: directed sequences, a vector table and randomized
// traffic compared against an instruction-level model of the exec/mem slice.
module tb_cpu_exec_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        ext_en;
  logic        ext_read_write;
  logic [15:0] ext_address;
  logic [31:0] ext_data_in;
  logic        fetch;
  logic [15:0] PC_out;
  logic        exec;
  logic [31:0] instruction;
  logic [31:0] source_1;
  logic [31:0] source_2;
  logic [31:0] data_out;
  logic [31:0] result;
  logic [3:0]  flags;
  logic [31:0] LDR;
  logic        ldr_valid;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state
  logic [31:0] mMem [64];
  logic [31:0] mDataOut, mResult, mLdr;
  logic [3:0]  mFlags;
  logic        mValid, mPend;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] expLdr;
    logic        expValid;
    logic [3:0]  expFlags;
  } vec_t;

  vec_t vecs[31];

  cpu_exec_mem dut (
    .clk(clk), .reset(reset),
    .ext_en(ext_en), .ext_read_write(ext_read_write),
    .ext_address(ext_address), .ext_data_in(ext_data_in),
    .fetch(fetch), .PC_out(PC_out),
    .exec(exec), .instruction(instruction),
    .source_1(source_1), .source_2(source_2),
    .data_out(data_out), .result(result), .flags(flags),
    .LDR(LDR), .ldr_valid(ldr_valid)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  function automatic logic [31:0] mkR(input logic [3:0] c, input logic [3:0] o, input logic s);
    return {c, o, s, 4'd1, 4'd2, 4'd3, 11'd0};
  endfunction

  function automatic logic [31:0] mkI(input logic [3:0] c, input logic [3:0] o, input logic s,
                                      input logic [15:0] im);
    return {c, o, s, 4'd1, im, 3'd0};
  endfunction

  // Condition table written straight from the mnemonic meanings
  function automatic bit condOk(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return 1'b1;
      4'h1: return z;
      4'h2: return !z;
      4'h3: return cy;
      4'h4: return !cy;
      4'h5: return n;
      4'h6: return !n;
      4'h7: return v;
      4'h8: return !v;
      4'h9: return cy && !z;
      4'hA: return !cy || z;
      4'hB: return n == v;
      4'hC: return n != v;
      4'hD: return !z && (n == v);
      4'hE: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic eEn, input logic eRw, input logic [15:0] eAddr,
                               input logic [31:0] eData, input logic fe, input logic [15:0] pc,
                               input logic ex, input logic [31:0] ins,
                               input logic [31:0] s1, input logic [31:0] s2);
    ext_en = eEn; ext_read_write = eRw; ext_address = eAddr; ext_data_in = eData;
    fetch = fe; PC_out = pc; exec = ex; instruction = ins;
    source_1 = s1; source_2 = s2;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic resetDut();
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  // One clock of the model, using the inputs currently driven
  task automatic modelStep();
    logic [31:0] a, b, val, imm16;
    logic [3:0]  op;
    logic [31:0] newLdr;
    bit newValid, newPend, ok, wb, fl, nc, nv;
    longint unsigned ua, ub;
    longint sr;
    a = source_1; op = instruction[27:24];
    imm16 = {16'h0, instruction[18:3]};
    b = (op == 4'h8 || op == 4'h9) ? imm16 : source_2;
    newLdr = mLdr; newValid = 0; newPend = 0; wb = 0; fl = 0; val = 0;
    nc = mFlags[1]; nv = mFlags[0];
    ok = exec && condOk(instruction[31:28], mFlags);
    if (mPend) begin newLdr = mDataOut; newValid = 1; end
    ua = a; ub = b;
    if (ok) begin
      case (op)
        4'h0, 4'h8: begin
          val = a + b; nc = (ua + ub) > 64'hFFFF_FFFF;
          sr = longint'(int'(a)) + longint'(int'(b)); nv = (sr != longint'(int'(val)));
          wb = 1; fl = instruction[23];
        end
        4'h1, 4'h9, 4'h7: begin
          val = a - b; nc = (ua >= ub);
          sr = longint'(int'(a)) - longint'(int'(b)); nv = (sr != longint'(int'(val)));
          wb = (op != 4'h7); fl = instruction[23] || (op == 4'h7);
        end
        4'h2: begin val = a & b;              wb = 1; fl = instruction[23]; end
        4'h3: begin val = a | b;              wb = 1; fl = instruction[23]; end
        4'h4: begin val = a ^ b;              wb = 1; fl = instruction[23]; end
        4'h5: begin val = b;                  wb = 1; fl = instruction[23]; end
        4'h6: begin val = imm16;              wb = 1; fl = instruction[23]; end
        4'hA: begin val = a << b[4:0];        wb = 1; fl = instruction[23]; end
        4'hB: begin val = a >> b[4:0];        wb = 1; fl = instruction[23]; end
        4'hC: begin val = ~b;                 wb = 1; fl = instruction[23]; end
        default: ;
      endcase
    end
    if (wb) begin
      mResult = val; newValid = 1;
      if (!mPend) newLdr = val;
    end
    if (fl) mFlags = {val[31], val == 32'h0, nc, nv};
    if (ext_en) begin
      if (ext_read_write) mDataOut = mMem[ext_address[5:0]];
      else mMem[ext_address[5:0]] = ext_data_in;
    end else if (ok && op == 4'hD) begin
      mDataOut = mMem[a[5:0]]; newPend = 1;
    end else if (ok && op == 4'hE) begin
      mMem[a[5:0]] = source_2;
    end else if (fetch) begin
      mDataOut = mMem[PC_out[5:0]];
    end
    mLdr = newLdr; mValid = newValid; mPend = newPend;
  endtask

  initial begin
    logic [31:0] word;
    logic [3:0]  rop, rcd;
    logic        rEn, rEx;
    logic [31:0] rIns, rS1, rS2;

    vecs[0]  = '{mkR(4'h0, 4'h0, 1'b1), 32'd7,         32'd5,         32'd12,        1'b1, 4'b0000};
    vecs[1]  = '{mkR(4'h0, 4'h0, 1'b1), 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 4'b0110};
    vecs[2]  = '{mkR(4'h0, 4'h0, 1'b1), 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1, 4'b1001};
    vecs[3]  = '{mkR(4'h0, 4'h1, 1'b1), 32'd5,         32'd5,         32'd0,         1'b1, 4'b0110};
    vecs[4]  = '{mkR(4'h0, 4'h1, 1'b1), 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b1, 4'b1000};
    vecs[5]  = '{mkR(4'h0, 4'h1, 1'b1), 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1, 4'b0011};
    vecs[6]  = '{mkR(4'h0, 4'h2, 1'b1), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1, 4'b1011};
    vecs[7]  = '{mkR(4'h0, 4'h3, 1'b1), 32'd0,         32'd0,         32'd0,         1'b1, 4'b0111};
    vecs[8]  = '{mkR(4'h0, 4'h4, 1'b1), 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987, 1'b1, 4'b1011};
    vecs[9]  = '{mkR(4'h0, 4'h5, 1'b1), 32'h1234,      32'h42,        32'h42,        1'b1, 4'b0011};
    vecs[10] = '{mkI(4'h0, 4'h6, 1'b1, 16'hBEEF), 32'd9, 32'd9,       32'h0000_BEEF, 1'b1, 4'b0011};
    vecs[11] = '{mkI(4'h0, 4'h8, 1'b1, 16'hFFFF), 32'h10, 32'd0,      32'h0001_000F, 1'b1, 4'b0000};
    vecs[12] = '{mkI(4'h0, 4'h9, 1'b1, 16'd2),   32'd1,  32'd0,       32'hFFFF_FFFF, 1'b1, 4'b1000};
    vecs[13] = '{mkR(4'h0, 4'hA, 1'b1), 32'd1,         32'h21,        32'd2,         1'b1, 4'b0000};
    vecs[14] = '{mkR(4'h0, 4'hB, 1'b1), 32'h8000_0000, 32'h1F,        32'd1,         1'b1, 4'b0000};
    vecs[15] = '{mkR(4'h0, 4'hB, 1'b1), 32'h8000_0000, 32'h20,        32'h8000_0000, 1'b1, 4'b1000};
    vecs[16] = '{mkR(4'h0, 4'hC, 1'b1), 32'd0,         32'hFFFF_FFFF, 32'd0,         1'b1, 4'b0100};
    vecs[17] = '{mkR(4'h0, 4'h7, 1'b0), 32'd7,         32'd9,         32'd0,         1'b0, 4'b1000};
    vecs[18] = '{mkR(4'h0, 4'h0, 1'b0), 32'd1,         32'd1,         32'd2,         1'b1, 4'b1000};
    vecs[19] = '{mkR(4'h0, 4'hF, 1'b1), 32'd1,         32'd1,         32'd2,         1'b0, 4'b1000};
    vecs[20] = '{mkR(4'h5, 4'h0, 1'b0), 32'd3,         32'd4,         32'd7,         1'b1, 4'b1000};
    vecs[21] = '{mkR(4'h6, 4'h0, 1'b0), 32'd3,         32'd5,         32'd7,         1'b0, 4'b1000};
    vecs[22] = '{mkR(4'hC, 4'h5, 1'b0), 32'd0,         32'h55,        32'h55,        1'b1, 4'b1000};
    vecs[23] = '{mkR(4'hB, 4'h5, 1'b0), 32'd0,         32'h99,        32'h55,        1'b0, 4'b1000};
    vecs[24] = '{mkR(4'hF, 4'h5, 1'b0), 32'd0,         32'h99,        32'h55,        1'b0, 4'b1000};
    vecs[25] = '{mkR(4'h4, 4'h5, 1'b1), 32'd0,         32'h66,        32'h66,        1'b1, 4'b0000};
    vecs[26] = '{mkR(4'h1, 4'h5, 1'b0), 32'd0,         32'h99,        32'h66,        1'b0, 4'b0000};
    vecs[27] = '{mkR(4'h9, 4'h5, 1'b0), 32'd0,         32'h99,        32'h66,        1'b0, 4'b0000};
    vecs[28] = '{mkR(4'h0, 4'h1, 1'b1), 32'd9,         32'd2,         32'd7,         1'b1, 4'b0010};
    vecs[29] = '{mkR(4'h9, 4'h5, 1'b0), 32'd0,         32'h77,        32'h77,        1'b1, 4'b0010};
    vecs[30] = '{mkR(4'hA, 4'h5, 1'b0), 32'd0,         32'h99,        32'h77,        1'b0, 4'b0010};

    // Reset values
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset data_out", data_out, 32'h0);
    checkOutput("reset result", result, 32'h0);
    checkOutput("reset flags", {28'h0, flags}, 32'h0);
    checkOutput("reset LDR", LDR, 32'h0);
    checkOutput("reset ldr_valid", {31'h0, ldr_valid}, 32'h0);

    // External write then read back
    word = {4'h0, 4'h6, 1'b0, 4'h2, 16'd5, 3'b000};
    applyStimulus(1, 0, 16'd0, word, 0, 16'd0, 0, 32'h0, 32'h0, 32'h0); tick();
    applyStimulus(1, 1, 16'd0, 32'h0, 0, 16'd0, 0, 32'h0, 32'h0, 32'h0); tick();
    checkOutput("ext readback", data_out, word);

    // MOVI strobe lasts exactly one cycle
    applyStimulus(0, 0, 16'd0, 32'h0, 0, 16'd0, 1, word, 32'h0, 32'h0); tick();
    checkOutput("movi LDR", LDR, 32'd5);
    checkOutput("movi valid", {31'h0, ldr_valid}, 32'd1);
    idle(); tick();
    checkOutput("movi valid drop", {31'h0, ldr_valid}, 32'd0);

    // STORE then external read
    applyStimulus(0, 0, 16'd0, 32'h0, 0, 16'd0, 1, mkR(4'h0, 4'hE, 1'b0), 32'd22, 32'd5); tick();
    checkOutput("store no valid", {31'h0, ldr_valid}, 32'd0);
    applyStimulus(1, 1, 16'd22, 32'h0, 0, 16'd0, 0, 32'h0, 32'h0, 32'h0); tick();
    checkOutput("store readback", data_out, 32'd5);
    checkOutput("store valid quiet", {31'h0, ldr_valid}, 32'd0);

    // ADD then LOAD with two-cycle write-back
    applyStimulus(0, 0, 16'd0, 32'h0, 0, 16'd0, 1, mkR(4'h0, 4'h0, 1'b0), 32'd7, 32'd5); tick();
    checkOutput("add LDR", LDR, 32'd12);
    applyStimulus(0, 0, 16'd0, 32'h0, 0, 16'd0, 1, mkR(4'h0, 4'hD, 1'b0), 32'd22, 32'd0); tick();
    checkOutput("load early valid", {31'h0, ldr_valid}, 32'd0);
    idle(); tick();
    checkOutput("load LDR", LDR, 32'd5);
    checkOutput("load valid", {31'h0, ldr_valid}, 32'd1);
    tick();
    checkOutput("load valid drop", {31'h0, ldr_valid}, 32'd0);

    // SUB sets Z/C, then conditional ADDs
    applyStimulus(0, 0, 16'd0, 32'h0, 0, 16'd0, 1, mkR(4'h0, 4'h1, 1'b1), 32'd5, 32'd5); tick();
    checkOutput("sub flags", {28'h0, flags}, 32'b0110);
    applyStimulus(0, 0, 16'd0, 32'h0, 0, 16'd0, 1, mkR(4'h2, 4'h0, 1'b0), 32'd1, 32'd2); tick();
    checkOutput("ne skipped valid", {31'h0, ldr_valid}, 32'd0);
    checkOutput("ne skipped LDR", LDR, 32'd0);
    applyStimulus(0, 0, 16'd0, 32'h0, 0, 16'd0, 1, mkR(4'h1, 4'h0, 1'b0), 32'd1, 32'd2); tick();
    checkOutput("eq exec valid", {31'h0, ldr_valid}, 32'd1);
    checkOutput("eq exec LDR", LDR, 32'd3);

    // Signed overflow, then reset during a LOAD
    applyStimulus(0, 0, 16'd0, 32'h0, 0, 16'd0, 1, mkR(4'h0, 4'h0, 1'b1), 32'h7FFF_FFFF, 32'd1); tick();
    checkOutput("ovf flags", {28'h0, flags}, 32'b1001);
    applyStimulus(0, 0, 16'd0, 32'h0, 0, 16'd0, 1, mkR(4'h0, 4'hD, 1'b0), 32'd22, 32'd0); tick();
    #1;
    reset = 1'b1;
    idle();
    #1;
    checkOutput("midload data_out", data_out, 32'h0);
    checkOutput("midload result", result, 32'h0);
    checkOutput("midload flags", {28'h0, flags}, 32'h0);
    checkOutput("midload LDR", LDR, 32'h0);
    checkOutput("midload valid", {31'h0, ldr_valid}, 32'h0);
    #2;
    reset = 1'b0;
    tick();
    checkOutput("aborted load valid", {31'h0, ldr_valid}, 32'd0);
    checkOutput("aborted load LDR", LDR, 32'd0);
    tick();
    checkOutput("aborted load valid2", {31'h0, ldr_valid}, 32'd0);

    // Vector table, back to back from a clean state
    resetDut();
    for (int i = 0; i < 31; i++) begin
      applyStimulus(0, 0, 16'd0, 32'h0, 0, 16'd0, 1, vecs[i].instr, vecs[i].s1, vecs[i].s2);
      tick();
      checkOutput($sformatf("vec%0d LDR", i), LDR, vecs[i].expLdr);
      checkOutput($sformatf("vec%0d result", i), result, vecs[i].expLdr);
      checkOutput($sformatf("vec%0d valid", i), {31'h0, ldr_valid}, {31'h0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d flags", i), {28'h0, flags}, {28'h0, vecs[i].expFlags});
    end

    // Randomized traffic against the model
    resetDut();
    mDataOut = 0; mResult = 0; mLdr = 0; mFlags = 0; mValid = 0; mPend = 0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1, 0, 16'(i), $urandom, 0, 16'd0, 0, 32'h0, 32'h0, 32'h0);
      modelStep();
      tick();
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      rEn = ($urandom_range(0, 7) == 0);
      rEx = mPend ? 1'b0 : ($urandom_range(0, 3) != 0);
      rop = 4'($urandom_range(0, 15));
      if (rEn && (rop == 4'hD || rop == 4'hE)) rop = 4'hF;
      rcd = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
      rIns = $urandom;
      rIns[31:28] = rcd;
      rIns[27:24] = rop;
      rS1 = $urandom;
      case ($urandom_range(0, 4))
        0: rS2 = 32'h0;
        1: rS2 = 32'hFFFF_FFFF;
        2: rS2 = 32'h8000_0000;
        3: rS2 = 32'h7FFF_FFFF;
        default: rS2 = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) rS1 = rS2;
      if (rop == 4'hD || rop == 4'hE) rS1[15:6] = 10'h0;
      applyStimulus(rEn, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), $urandom,
                    1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), rEx, rIns, rS1, rS2);
      modelStep();
      tick();
      checkOutput($sformatf("rnd%0d data_out", cyc), data_out, mDataOut);
      checkOutput($sformatf("rnd%0d result", cyc), result, mResult);
      checkOutput($sformatf("rnd%0d flags", cyc), {28'h0, flags}, {28'h0, mFlags});
      checkOutput($sformatf("rnd%0d LDR", cyc), LDR, mLdr);
      checkOutput($sformatf("rnd%0d valid", cyc), {31'h0, ldr_valid}, {31'h0, mValid});
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
